// File: rtl/booth_mul_arbiter_if.sv
// rtl/booth_mul_arbiter_if.sv - request/response bundle between requesters, consumer and the multiplier arbiter
interface booth_mul_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [2*WIDTH-1:0]    resp_product;
  logic                  resp_err;
  logic                  resp_ready;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_product, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_product, resp_err
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin sharing of one sequential Booth multiplier core with watchdog abort
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               reset_i,
  booth_mul_arbiter_if.slave bus,
  output logic               core_start_o,
  output logic [WIDTH-1:0]   core_a_o,
  output logic [WIDTH-1:0]   core_b_o,
  input  logic [2*WIDTH-1:0] core_product_i,
  input  logic               core_done_i,
  output logic               busy_o
);
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IDW1 = IDW + 1;
  localparam int WDW  = $clog2(TIMEOUT + 1);
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    product_q, product_d;
  logic             err_q, err_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW1-1:0]  cand;

  // Search starts at rr_ptr and wraps modulo NREQ; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + IDW1'(k);
      if (cand >= IDW1'(NREQ)) begin
        cand = cand - IDW1'(NREQ);
      end
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    wd_cnt_d      = wd_cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    product_d     = product_q;
    err_d         = err_q;
    bus.req_ready = '0;
    core_start_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          bus.req_ready[grant_idx] = 1'b1;
          a_d     = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
          b_d     = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
          id_d    = grant_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_start_o = 1'b1;
        wd_cnt_d     = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last allowed cycle still beats the watchdog.
        if (core_done_i) begin
          product_d = core_product_i;
          err_d     = 1'b0;
          state_d   = S_RESP;
        end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
          product_d = '0;
          err_d     = 1'b1;
          state_d   = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      wd_cnt_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      wd_cnt_q  <= wd_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
      err_q     <= err_d;
    end
  end

  assign bus.resp_valid   = (state_q == S_RESP);
  assign bus.resp_id      = id_q;
  assign bus.resp_product = product_q;
  assign bus.resp_err     = err_q;
  assign core_a_o         = a_q;
  assign core_b_o         = b_q;
  assign busy_o           = (state_q != S_IDLE);
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - randomized self-checking bench for booth_mul_arbiter
module tb_booth_mul_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int PW      = 2 * WIDTH;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             core_start;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [PW-1:0]    core_product;
  logic             core_done;
  logic             busy;

  booth_mul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .bus            (bus.slave),
    .core_start_o   (core_start),
    .core_a_o       (core_a),
    .core_b_o       (core_b),
    .core_product_i (core_product),
    .core_done_i    (core_done),
    .busy_o         (busy)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int rr    = 0;
  bit               pend [NREQ];
  logic [WIDTH-1:0] pa   [NREQ];
  logic [WIDTH-1:0] pb   [NREQ];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return PW'(sa * sb);
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]            = pend[i];
      bus.req_a[i*WIDTH +: WIDTH] = pa[i];
      bus.req_b[i*WIDTH +: WIDTH] = pb[i];
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    pa[i]   = WIDTH'($urandom);
    pb[i]   = WIDTH'($urandom);
  endtask

  // dly: WAIT cycle (1-based) carrying core_done; beyond TIMEOUT means the core never answers.
  task automatic do_op(input int dly, input int bp, input bit stray, input bit refill);
    int g;
    int waited;
    int nw;
    logic [WIDTH-1:0] ea, eb;
    logic [PW-1:0] ep;
    logic ee;
    g = model_winner();
    waited = 0;
    drive_reqs();
    #1;
    while (bus.req_ready == '0 && waited < 20) begin
      step();
      drive_reqs();
      #1;
      waited++;
    end
    check_eq("grant", 32'(bus.req_ready), 32'(1 << g));
    check_eq("busy_idle", 32'(busy), 0);
    ea = pa[g];
    eb = pb[g];
    ee = (dly > TIMEOUT);
    ep = ee ? '0 : ref_mul(ea, eb);
    pend[g] = 1'b0;
    if (refill) new_req(g);
    step();
    drive_reqs();
    #1;
    check_eq("start", 32'(core_start), 1);
    check_eq("core_a", 32'(core_a), 32'(ea));
    check_eq("core_b", 32'(core_b), 32'(eb));
    check_eq("ready_issue", 32'(bus.req_ready), 0);
    step();
    nw = ee ? TIMEOUT : dly;
    for (int w = 1; w <= nw; w++) begin
      core_done    = (w == dly);
      core_product = (w == dly) ? ref_mul(ea, eb) : PW'($urandom);
      #1;
      check_eq("start_wait", 32'(core_start), 0);
      check_eq("resp_early", 32'(bus.resp_valid), 0);
      check_eq("ready_wait", 32'(bus.req_ready), 0);
      check_eq("core_a_hold", 32'(core_a), 32'(ea));
      step();
    end
    core_done = 1'b0;
    for (int c = 0; c <= bp; c++) begin
      bus.resp_ready = (c == bp);
      core_done      = stray && (c == 0);
      core_product   = PW'($urandom);
      #1;
      check_eq("resp_valid", 32'(bus.resp_valid), 1);
      check_eq("resp_id", 32'(bus.resp_id), 32'(g));
      check_eq("resp_product", 32'(bus.resp_product), 32'(ep));
      check_eq("resp_err", 32'(bus.resp_err), 32'(ee));
      check_eq("ready_resp", 32'(bus.req_ready), 0);
      check_eq("start_resp", 32'(core_start), 0);
      check_eq("core_b_hold", 32'(core_b), 32'(eb));
      step();
    end
    bus.resp_ready = 1'b0;
    core_done      = 1'b0;
    rr = (g + 1) % NREQ;
    check_eq("busy_after", 32'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_rvalid"}, 32'(bus.resp_valid), 0);
    check_eq({tag, "_rid"}, 32'(bus.resp_id), 0);
    check_eq({tag, "_rprod"}, 32'(bus.resp_product), 0);
    check_eq({tag, "_rerr"}, 32'(bus.resp_err), 0);
    check_eq({tag, "_start"}, 32'(core_start), 0);
    check_eq({tag, "_a"}, 32'(core_a), 0);
    check_eq({tag, "_b"}, 32'(core_b), 0);
    check_eq({tag, "_ready"}, 32'(bus.req_ready), 0);
  endtask

  initial begin
    logic [PW-1:0] held;
    reset_i        = 1'b1;
    core_done      = 1'b0;
    core_product   = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      pa[i]   = '0;
      pb[i]   = '0;
    end
    drive_reqs();
    step();
    step();
    check_all_zero("reset");
    reset_i = 1'b0;
    step();

    pend[0] = 1'b1;
    pa[0]   = 4'd3;
    pb[0]   = 4'hE;
    do_op(4, 0, 1'b0, 1'b0);

    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    rr = 0;
    for (int i = 0; i < NREQ; i++) new_req(i);
    for (int k = 0; k < 5; k++) do_op($urandom_range(1, 6), 0, 1'b0, 1'b1);

    do_op(3, 5, 1'b0, 1'b1);
    do_op(TIMEOUT + 1, 1, 1'b0, 1'b1);
    do_op(TIMEOUT, 0, 1'b0, 1'b1);
    do_op(1, 2, 1'b1, 1'b1);

    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    new_req(2);
    drive_reqs();
    #1;
    check_eq("rst_grant", 32'(bus.req_ready), 32'(1 << 2));
    pend[2] = 1'b0;
    step();
    drive_reqs();
    step();
    step();
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    rr = 0;
    #1;
    check_all_zero("wait_reset");
    core_done    = 1'b1;
    core_product = PW'($urandom);
    step();
    core_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("late_done_rvalid", 32'(bus.resp_valid), 0);
      check_eq("late_done_busy", 32'(busy), 0);
      step();
    end

    held         = bus.resp_product;
    core_done    = 1'b1;
    core_product = PW'($urandom);
    #1;
    check_eq("stray_idle_busy", 32'(busy), 0);
    step();
    core_done = 1'b0;
    #1;
    check_eq("stray_idle_busy2", 32'(busy), 0);
    check_eq("stray_idle_rvalid", 32'(bus.resp_valid), 0);
    check_eq("stray_idle_prod", 32'(bus.resp_product), 32'(held));

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0: pend[i] = 1'b0;
          1: new_req(i);
          default: ;
        endcase
      end
      if (model_winner() < 0) new_req($urandom_range(0, NREQ - 1));
      do_op($urandom_range(1, TIMEOUT + 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
